// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired CPU control unit: opcodes, ALU codes,
// sequencer mode/step encodings and the instruction-class enum.
// Latency: n/a (declarations only). Backpressure: n/a.
package cpu_ctrl_pkg;

  localparam int OPCODE_W = 5;
  localparam int NSTEP_W  = 3;

  typedef logic [OPCODE_W-1:0] opcode_t;
  typedef logic [NSTEP_W-1:0]  step_t;

  // Opcodes as found in IR[31:27]
  localparam opcode_t OP_LD   = 5'd0;
  localparam opcode_t OP_LDI  = 5'd1;
  localparam opcode_t OP_ST   = 5'd2;
  localparam opcode_t OP_ADD  = 5'd3;
  localparam opcode_t OP_SUB  = 5'd4;
  localparam opcode_t OP_AND  = 5'd5;
  localparam opcode_t OP_OR   = 5'd6;
  localparam opcode_t OP_SHR  = 5'd7;
  localparam opcode_t OP_SHRA = 5'd8;
  localparam opcode_t OP_SHL  = 5'd9;
  localparam opcode_t OP_ROR  = 5'd10;
  localparam opcode_t OP_ROL  = 5'd11;
  localparam opcode_t OP_ADDI = 5'd12;
  localparam opcode_t OP_ANDI = 5'd13;
  localparam opcode_t OP_ORI  = 5'd14;
  localparam opcode_t OP_MUL  = 5'd15;
  localparam opcode_t OP_DIV  = 5'd16;
  localparam opcode_t OP_NEG  = 5'd17;
  localparam opcode_t OP_NOT  = 5'd18;
  localparam opcode_t OP_BRX  = 5'd19;
  localparam opcode_t OP_JR   = 5'd20;
  localparam opcode_t OP_IN   = 5'd22;
  localparam opcode_t OP_OUT  = 5'd23;
  localparam opcode_t OP_MFHI = 5'd24;
  localparam opcode_t OP_MFLO = 5'd25;
  localparam opcode_t OP_NOP  = 5'd26;
  localparam opcode_t OP_HALT = 5'd27;

  // ALU operation code used for address/offset arithmetic
  localparam opcode_t ALU_ADD = 5'd3;

  typedef enum logic [1:0] {
    MODE_RESET = 2'd0,
    MODE_EXEC  = 2'd1,
    MODE_HALT  = 2'd2
  } mode_e;

  localparam step_t STEP_T0 = 3'd0;
  localparam step_t STEP_T1 = 3'd1;
  localparam step_t STEP_T2 = 3'd2;
  localparam step_t STEP_T3 = 3'd3;
  localparam step_t STEP_T4 = 3'd4;
  localparam step_t STEP_T5 = 3'd5;
  localparam step_t STEP_T6 = 3'd6;
  localparam step_t STEP_T7 = 3'd7;

  typedef enum logic [3:0] {
    CLS_ALU3     = 4'd0,
    CLS_IMM      = 4'd1,
    CLS_LD       = 4'd2,
    CLS_LDI      = 4'd3,
    CLS_ST       = 4'd4,
    CLS_MULDIV   = 4'd5,
    CLS_UNARY    = 4'd6,
    CLS_BR       = 4'd7,
    CLS_ONE_STEP = 4'd8,
    CLS_NOP      = 4'd9,
    CLS_HALT     = 4'd10
  } opclass_e;

endpackage

// File: rtl/control_unit_opclass_decode.sv
// Maps an opcode to its instruction class and the index of its final step.
// Latency: combinational. Backpressure: none.
// Ports: opcode in (IR[31:27]); op_class out (class enum); last_step out (T2..T7).
module opclass_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output opclass_e            op_class,
  output logic [NSTEP_W-1:0]  last_step
);

  always_comb begin
    op_class = CLS_NOP;
    case (opcode)
      OP_LD:   op_class = CLS_LD;
      OP_LDI:  op_class = CLS_LDI;
      OP_ST:   op_class = CLS_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
               op_class = CLS_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:
               op_class = CLS_IMM;
      OP_MUL, OP_DIV:
               op_class = CLS_MULDIV;
      OP_NEG, OP_NOT:
               op_class = CLS_UNARY;
      OP_BRX:  op_class = CLS_BR;
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:
               op_class = CLS_ONE_STEP;
      OP_HALT: op_class = CLS_HALT;
      default: op_class = CLS_NOP;   // nop and unassigned opcodes
    endcase
  end

  always_comb begin
    last_step = STEP_T2;
    case (op_class)
      CLS_ALU3, CLS_IMM, CLS_LDI: last_step = STEP_T5;
      CLS_LD, CLS_ST:             last_step = STEP_T7;
      CLS_MULDIV, CLS_BR:         last_step = STEP_T6;
      CLS_UNARY:                  last_step = STEP_T4;
      CLS_ONE_STEP:               last_step = STEP_T3;
      default:                    last_step = STEP_T2;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer generating every datapath control strobe: fetch T0-T2, execute T3-T7.
// Latency: strobes are combinational from the registered {mode, step}; one step per clk.
// Backpressure: none; stop is honoured only at an instruction's last step.
// Ports: clk, clr (sync active-low), stop, IR, branch_flag in; bus drivers, register
// loads, memory strobes, select/encode controls, operation[4:0] and Run out.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        stop,
  input  logic [31:0] IR,
  input  logic        branch_flag,
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHIin,
  output logic        ZLOin,
  output logic        CONin,
  output logic        OutPortin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  operation,
  output logic        Run
);

  logic [OPCODE_W-1:0] opcode;
  assign opcode = IR[31 -: OPCODE_W];

  // Operand fields are consumed by the datapath, not by the sequencer.
  logic unused_ir;
  assign unused_ir = ^IR[31-OPCODE_W:0];

  mode_e              mode_q, mode_d;
  logic [NSTEP_W-1:0] step_q, step_d;
  opclass_e           op_class;
  logic [NSTEP_W-1:0] last_step;

  opclass_decode u_decode (
    .opcode    (opcode),
    .op_class  (op_class),
    .last_step (last_step)
  );

  // Next state. The T2 decision (nop/halt) reads the opcode presented on IR
  // during that step.
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    case (mode_q)
      MODE_RESET: begin
        mode_d = MODE_EXEC;
        step_d = STEP_T0;
      end
      MODE_EXEC: begin
        if (step_q == last_step) begin
          step_d = STEP_T0;
          if (op_class == CLS_HALT || stop) mode_d = MODE_HALT;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      MODE_HALT: begin
        mode_d = MODE_HALT;
        step_d = STEP_T0;
      end
      default: begin
        mode_d = MODE_RESET;
        step_d = STEP_T0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      mode_q <= MODE_RESET;
      step_q <= STEP_T0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  // Strobe decode; everything stays low outside EXEC.
  always_comb begin
    {PCout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, MDRout,
     MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Write, HIin, LOin,
     ZHIin, ZLOin, CONin, OutPortin, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    operation = '0;
    Run       = (mode_q == MODE_EXEC);

    if (mode_q == MODE_EXEC) begin
      case (step_q)
        STEP_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1; end
        STEP_T1: begin ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
        STEP_T2: begin MDRout = 1'b1; IRin = 1'b1; end
        default: begin
          case (op_class)
            CLS_ALU3, CLS_IMM: begin
              case (step_q)
                STEP_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                STEP_T4: begin
                  // Immediate forms take the second operand from the C field
                  if (op_class == CLS_IMM) begin
                    Cout = 1'b1;
                  end else begin
                    Grc  = 1'b1;
                    Rout = 1'b1;
                  end
                  operation = opcode;
                  ZLOin     = 1'b1;
                end
                STEP_T5: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
              endcase
            end
            CLS_LD, CLS_LDI, CLS_ST: begin
              // Shared effective-address computation: base (or 0 via BAout) + C
              case (step_q)
                STEP_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                STEP_T4: begin Cout = 1'b1; operation = ALU_ADD; ZLOin = 1'b1; end
                STEP_T5: begin
                  ZLowout = 1'b1;
                  if (op_class == CLS_LDI) begin
                    Gra = 1'b1;
                    Rin = 1'b1;
                  end else begin
                    MARin = 1'b1;
                  end
                end
                STEP_T6: begin
                  MDRin = 1'b1;
                  // Loads pull from memory; stores leave Read low so MDR takes the bus
                  if (op_class == CLS_LD) begin
                    Read = 1'b1;
                  end else begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                  end
                end
                STEP_T7: begin
                  if (op_class == CLS_LD) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    Rin    = 1'b1;
                  end else begin
                    Write = 1'b1;
                  end
                end
                default: ;
              endcase
            end
            CLS_MULDIV: begin
              case (step_q)
                STEP_T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                STEP_T4: begin
                  Grb = 1'b1; Rout = 1'b1; operation = opcode; ZHIin = 1'b1; ZLOin = 1'b1;
                end
                STEP_T5: begin ZLowout = 1'b1; LOin = 1'b1; end
                STEP_T6: begin ZHighout = 1'b1; HIin = 1'b1; end
                default: ;
              endcase
            end
            CLS_UNARY: begin
              case (step_q)
                STEP_T3: begin Grb = 1'b1; Rout = 1'b1; operation = opcode; ZLOin = 1'b1; end
                STEP_T4: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
              endcase
            end
            CLS_BR: begin
              case (step_q)
                STEP_T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                STEP_T4: begin PCout = 1'b1; Yin = 1'b1; end
                STEP_T5: begin Cout = 1'b1; operation = ALU_ADD; ZLOin = 1'b1; end
                STEP_T6: begin ZLowout = 1'b1; PCin = branch_flag; end
                default: ;
              endcase
            end
            CLS_ONE_STEP: begin
              if (step_q == STEP_T3) begin
                case (opcode)
                  OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                  OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                  OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  default: ;
                endcase
              end
            end
            default: ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios plus random instruction streams
// checked against a per-opcode step schedule model.
module tb_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr, stop, branch_flag;
  logic [31:0] IR;
  logic PCout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout, MDRout;
  logic MARin, PCin, MDRin, IRin, Yin, IncPC, Read, Write, HIin, LOin;
  logic ZHIin, ZLOin, CONin, OutPortin, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] operation;
  logic Run;

  control_unit dut (
    .clk(clk), .clr(clr), .stop(stop), .IR(IR), .branch_flag(branch_flag),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .MDRout(MDRout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .HIin(HIin), .LOin(LOin),
    .ZHIin(ZHIin), .ZLOin(ZLOin), .CONin(CONin), .OutPortin(OutPortin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .operation(operation), .Run(Run)
  );

  logic [27:0] obs;
  assign obs = {BAout, Rout, Rin, Grc, Grb, Gra, OutPortin, CONin, ZLOin, ZHIin,
                LOin, HIin, Write, Read, IncPC, Yin, IRin, MDRin, PCin, MARin,
                MDRout, Cout, InPortout, LOout, HIout, ZLowout, ZHighout, PCout};

  localparam logic [27:0] PCOUT = 28'd1 << 0,  ZHIGHOUT = 28'd1 << 1,  ZLOWOUT = 28'd1 << 2;
  localparam logic [27:0] HIOUT = 28'd1 << 3,  LOOUT    = 28'd1 << 4,  INPORTOUT = 28'd1 << 5;
  localparam logic [27:0] COUT  = 28'd1 << 6,  MDROUT   = 28'd1 << 7,  MARIN   = 28'd1 << 8;
  localparam logic [27:0] PCIN  = 28'd1 << 9,  MDRIN    = 28'd1 << 10, IRIN    = 28'd1 << 11;
  localparam logic [27:0] YIN   = 28'd1 << 12, INCPC    = 28'd1 << 13, READ    = 28'd1 << 14;
  localparam logic [27:0] WRITE = 28'd1 << 15, HIIN     = 28'd1 << 16, LOIN    = 28'd1 << 17;
  localparam logic [27:0] ZHIIN = 28'd1 << 18, ZLOIN    = 28'd1 << 19, CONIN   = 28'd1 << 20;
  localparam logic [27:0] OUTPORTIN = 28'd1 << 21, GRA  = 28'd1 << 22, GRB     = 28'd1 << 23;
  localparam logic [27:0] GRC   = 28'd1 << 24, RIN      = 28'd1 << 25, ROUT    = 28'd1 << 26;
  localparam logic [27:0] BAOUT = 28'd1 << 27;

  int checks = 0;
  int passed = 0;

  // Expected schedule of the instruction under test
  logic [27:0] es [8];
  logic [4:0]  eo [8];
  int          en;
  bit          ehalt;

  task automatic chk(input string tag, input int step, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passed++;
    else $error("FAIL %s step=T%0d observed=%h expected=%h", tag, step, o, e);
  endtask

  task automatic fill(input logic [4:0] op, input logic bf);
    for (int i = 0; i < 8; i++) begin es[i] = '0; eo[i] = '0; end
    es[0] = PCOUT | MARIN | INCPC | ZLOIN;
    es[1] = ZLOWOUT | PCIN | READ | MDRIN;
    es[2] = MDROUT | IRIN;
    en = 3;
    ehalt = (op == 5'd27);
    if (op >= 5'd3 && op <= 5'd14) begin
      es[3] = GRB | ROUT | YIN;
      es[4] = ((op >= 5'd12) ? COUT : (GRC | ROUT)) | ZLOIN; eo[4] = op;
      es[5] = ZLOWOUT | GRA | RIN;
      en = 6;
    end else if (op <= 5'd2) begin
      es[3] = GRB | BAOUT | YIN;
      es[4] = COUT | ZLOIN; eo[4] = 5'd3;
      if (op == 5'd1) begin
        es[5] = ZLOWOUT | GRA | RIN;
        en = 6;
      end else begin
        es[5] = ZLOWOUT | MARIN;
        es[6] = (op == 5'd0) ? (READ | MDRIN) : (GRA | ROUT | MDRIN);
        es[7] = (op == 5'd0) ? (MDROUT | GRA | RIN) : WRITE;
        en = 8;
      end
    end else if (op == 5'd15 || op == 5'd16) begin
      es[3] = GRA | ROUT | YIN;
      es[4] = GRB | ROUT | ZHIIN | ZLOIN; eo[4] = op;
      es[5] = ZLOWOUT | LOIN;
      es[6] = ZHIGHOUT | HIIN;
      en = 7;
    end else if (op == 5'd17 || op == 5'd18) begin
      es[3] = GRB | ROUT | ZLOIN; eo[3] = op;
      es[4] = ZLOWOUT | GRA | RIN;
      en = 5;
    end else if (op == 5'd19) begin
      es[3] = GRA | ROUT | CONIN;
      es[4] = PCOUT | YIN;
      es[5] = COUT | ZLOIN; eo[5] = 5'd3;
      es[6] = ZLOWOUT | (bf ? PCIN : 28'd0);
      en = 7;
    end else if (op == 5'd20) begin es[3] = GRA | ROUT | PCIN;        en = 4;
    end else if (op == 5'd22) begin es[3] = INPORTOUT | GRA | RIN;    en = 4;
    end else if (op == 5'd23) begin es[3] = GRA | ROUT | OUTPORTIN;   en = 4;
    end else if (op == 5'd24) begin es[3] = HIOUT | GRA | RIN;        en = 4;
    end else if (op == 5'd25) begin es[3] = LOOUT | GRA | RIN;        en = 4;
    end
  endtask

  // Starts at a negedge; ends at a negedge with the DUT in EXEC/T0.
  task automatic do_reset();
    clr = 1'b0;
    @(negedge clk); #1;
    chk("reset_strobes", 0, {4'd0, obs}, 32'd0);
    chk("reset_operation", 0, {27'd0, operation}, 32'd0);
    chk("reset_run", 0, {31'd0, Run}, 32'd0);
    clr = 1'b1;
    @(negedge clk);
  endtask

  // Runs one instruction from T0. stop is high for steps sf..su;
  // abort >= 0 pulls clr low during that step.
  task automatic run_instr(input logic [4:0] op, input logic [26:0] low, input logic bf,
                           input int sf, input int su, input int abort);
    bit halt_exp;
    fill(op, bf);
    IR = {op, low};
    branch_flag = bf;
    for (int k = 0; k < en; k++) begin
      if (k > 0) @(negedge clk);
      stop = (k >= sf && k <= su);
      #1;
      chk($sformatf("strobes_op%0d", op), k, {4'd0, obs}, {4'd0, es[k]});
      chk($sformatf("operation_op%0d", op), k, {27'd0, operation}, {27'd0, eo[k]});
      chk($sformatf("run_op%0d", op), k, {31'd0, Run}, 32'd1);
      if (k == abort) begin
        stop = 1'b0;
        do_reset();
        return;
      end
    end
    halt_exp = ehalt || (en - 1 >= sf && en - 1 <= su);
    @(negedge clk);
    stop = 1'b0;
    if (halt_exp) begin
      repeat (2) begin
        #1;
        chk($sformatf("halt_strobes_op%0d", op), 0, {4'd0, obs}, 32'd0);
        chk($sformatf("halt_run_op%0d", op), 0, {31'd0, Run}, 32'd0);
        @(negedge clk);
      end
      do_reset();
    end
  endtask

  initial begin
    clr = 1'b0; stop = 1'b0; branch_flag = 1'b0; IR = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("init_strobes", 0, {4'd0, obs}, 32'd0);
    chk("init_run", 0, {31'd0, Run}, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    // add R1,R2,R3 = 0x18918000
    run_instr(5'd3, 27'h0918000, 1'b0, -1, -1, -1);
    // ld full eight steps, then ld interrupted by reset at T5
    run_instr(5'd0, 27'($urandom), 1'b0, -1, -1, -1);
    run_instr(5'd0, 27'($urandom), 1'b0, -1, -1, 5);
    // st, brx both ways, mul
    run_instr(5'd2, 27'($urandom), 1'b0, -1, -1, -1);
    run_instr(5'd19, 27'($urandom), 1'b0, -1, -1, -1);
    run_instr(5'd19, 27'($urandom), 1'b1, -1, -1, -1);
    run_instr(5'd15, 27'($urandom), 1'b0, -1, -1, -1);
    // stop pulse mid-instruction is ignored
    run_instr(5'd3, 27'($urandom), 1'b0, 3, 4, -1);
    // stop raised at T4 of add and held: halts after T5
    run_instr(5'd3, 27'($urandom), 1'b0, 4, 7, -1);
    // halt opcode
    run_instr(5'd27, 27'($urandom), 1'b0, -1, -1, -1);
    run_instr(5'd26, 27'($urandom), 1'b0, -1, -1, -1);

    for (int i = 0; i < 60; i++) begin
      int sf, su;
      if ($urandom_range(0, 3) == 0) begin
        sf = int'($urandom_range(0, 7));
        su = sf + int'($urandom_range(0, 2));
      end else begin
        sf = -1; su = -1;
      end
      run_instr(5'($urandom_range(0, 31)), 27'($urandom), 1'($urandom_range(0, 1)), sf, su,
                ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
